gnn_node_scheduler: RTL

- Time-multiplexed controller for the 4-node GNN. One shared dnn_top engine replaces four parallel instances.
- Captures all 16 node features. Computes each node's neighbour-aggregated input vector and issues the 4 nodes to the engine sequentially.
- Buffers the raw engine outputs, then performs output-side neighbour aggregation and presents all 8 results with a single ready pulse.

---
 rtl/gnn_node_scheduler_if.sv | 26 ++
 rtl/gnn_node_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gnn_node_scheduler_if.sv
// Handshake and data bus between the GNN node scheduler, its requester and the
// shared dnn engine; clock and reset stay outside.
interface gnn_node_scheduler_if;
  logic         in_ready;
  logic [79:0]  x_flat;
  logic         busy;
  logic         eng_start;
  logic [27:0]  eng_x_flat;
  logic [19:0]  eng_out0;
  logic [19:0]  eng_out1;
  logic         eng_out0_ready;
  logic         eng_out1_ready;
  logic [167:0] out_flat;
  logic         out_ready;
  logic         err_timeout;

  modport slave (
    input  in_ready, x_flat, eng_out0, eng_out1, eng_out0_ready, eng_out1_ready,
    output busy, eng_start, eng_x_flat, out_flat, out_ready, err_timeout
  );

  modport master (
    output in_ready, x_flat, eng_out0, eng_out1, eng_out0_ready, eng_out1_ready,
    input  busy, eng_start, eng_x_flat, out_flat, out_ready, err_timeout
  );
endinterface

// File: rtl/gnn_node_scheduler.sv
// Time-multiplexed 4-node GNN controller: aggregates neighbour features, issues the
// nodes one at a time to a shared engine, then aggregates the buffered engine results.
module gnn_node_scheduler #(
  parameter int unsigned TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  gnn_node_scheduler_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_AGG   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Neighbour j (0 or 1) of node n, excluding the node itself.
  function automatic logic [1:0] nbr(input logic [1:0] n, input logic j);
    logic [1:0] r;
    case (n)
      2'd0:    r = j ? 2'd2 : 2'd1;
      2'd1:    r = j ? 2'd3 : 2'd0;
      2'd2:    r = j ? 2'd3 : 2'd0;
      2'd3:    r = j ? 2'd2 : 2'd1;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic [6:0] sx7(input logic [4:0] v);
    return {{2{v[4]}}, v};
  endfunction

  function automatic logic [20:0] sx21(input logic [19:0] v);
    return {v[19], v};
  endfunction

  function automatic logic [27:0] agg_in(input logic [79:0] feat, input logic [1:0] n);
    logic [27:0] r;
    int          self_i;
    int          a_i;
    int          b_i;
    r      = {28{1'b0}};
    self_i = int'(n);
    a_i    = int'(nbr(n, 1'b0));
    b_i    = int'(nbr(n, 1'b1));
    for (int f = 0; f < 4; f++) begin
      r[7*f +: 7] = sx7(feat[(4*self_i+f)*5 +: 5]) + sx7(feat[(4*a_i+f)*5 +: 5])
                  + sx7(feat[(4*b_i+f)*5 +: 5]);
    end
    return r;
  endfunction

  state_e         state_q, state_d;
  logic [1:0]     node_q, node_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [79:0]    feat_q, feat_d;
  logic [19:0]    raw0_q [4];
  logic [19:0]    raw0_d [4];
  logic [19:0]    raw1_q [4];
  logic [19:0]    raw1_d [4];
  logic [27:0]    eng_x_q, eng_x_d;
  logic [167:0]   out_flat_q, out_flat_d;
  logic           busy_q, busy_d;
  logic           eng_start_q, eng_start_d;
  logic           out_ready_q, out_ready_d;
  logic           err_q, err_d;
  logic [167:0]   agg_out_s;
  logic           both_ready_s;

  assign both_ready_s = bus.eng_out0_ready & bus.eng_out1_ready;

  // Output-side aggregation of the buffered raw engine results, wrapping mod 2^21.
  always_comb begin
    agg_out_s = {168{1'b0}};
    for (int n = 0; n < 4; n++) begin
      agg_out_s[(2*n)*21 +: 21]   = sx21(raw0_q[n]) + sx21(raw0_q[nbr(2'(n), 1'b0)])
                                  + sx21(raw0_q[nbr(2'(n), 1'b1)]);
      agg_out_s[(2*n+1)*21 +: 21] = sx21(raw1_q[n]) + sx21(raw1_q[nbr(2'(n), 1'b0)])
                                  + sx21(raw1_q[nbr(2'(n), 1'b1)]);
    end
  end

  // Next-state and next-output logic for the issue/collect sequence.
  always_comb begin
    state_d     = state_q;
    node_d      = node_q;
    timer_d     = timer_q;
    feat_d      = feat_q;
    raw0_d      = raw0_q;
    raw1_d      = raw1_q;
    eng_x_d     = eng_x_q;
    out_flat_d  = out_flat_q;
    err_d       = err_q;
    eng_start_d = 1'b0;
    out_ready_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_ready) begin
          feat_d      = bus.x_flat;
          node_d      = 2'd0;
          err_d       = 1'b0;
          eng_x_d     = agg_in(bus.x_flat, 2'd0);
          eng_start_d = 1'b1;
          state_d     = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        timer_d = {TW{1'b0}};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (both_ready_s) begin
          raw0_d[node_q] = bus.eng_out0;
          raw1_d[node_q] = bus.eng_out1;
          if (node_q == 2'd3) begin
            state_d = S_AGG;
          end else begin
            node_d      = node_q + 2'd1;
            eng_x_d     = agg_in(feat_q, node_q + 2'd1);
            eng_start_d = 1'b1;
            state_d     = S_ISSUE;
          end
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      S_AGG: begin
        out_flat_d  = agg_out_s;
        out_ready_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      node_q      <= 2'd0;
      timer_q     <= {TW{1'b0}};
      feat_q      <= 80'd0;
      for (int i = 0; i < 4; i++) begin
        raw0_q[i] <= 20'd0;
        raw1_q[i] <= 20'd0;
      end
      eng_x_q     <= 28'd0;
      out_flat_q  <= 168'd0;
      busy_q      <= 1'b0;
      eng_start_q <= 1'b0;
      out_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      node_q      <= node_d;
      timer_q     <= timer_d;
      feat_q      <= feat_d;
      raw0_q      <= raw0_d;
      raw1_q      <= raw1_d;
      eng_x_q     <= eng_x_d;
      out_flat_q  <= out_flat_d;
      busy_q      <= busy_d;
      eng_start_q <= eng_start_d;
      out_ready_q <= out_ready_d;
      err_q       <= err_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.eng_start   = eng_start_q;
  assign bus.eng_x_flat  = eng_x_q;
  assign bus.out_flat    = out_flat_q;
  assign bus.out_ready   = out_ready_q;
  assign bus.err_timeout = err_q;

endmodule
